// File: rtl/mdclcg_pkg.sv
// -----------------------------------------------------------------------------
// mdclcg_pkg
// Shared definitions for the MDCLCG carry-save multiplier path.
//   MDCLCG_W     default operand width of the carry-save vectors
//   MDCLCG_SEGS  default number of carry-resolve pipeline segments
//   ha1 / fa1    single-bit half/full adder cells, each returning {carry, sum}
// -----------------------------------------------------------------------------
package mdclcg_pkg;

   localparam int MDCLCG_W    = 64;
   localparam int MDCLCG_SEGS = 4;

   // Half adder cell: {carry, sum} of two bits.
   function automatic logic [1:0] ha1(input logic i_a, input logic i_b);
      return {i_a & i_b, i_a ^ i_b};
   endfunction

   // Full adder cell: {carry, sum} of three bits.
   function automatic logic [1:0] fa1(input logic i_a, input logic i_b, input logic i_c);
      return {(i_a & i_b) | (i_c & (i_a ^ i_b)), i_a ^ i_b ^ i_c};
   endfunction

endpackage : mdclcg_pkg

// File: rtl/csa_seg_add.sv
// -----------------------------------------------------------------------------
// csa_seg_add
// Combinational SW-bit ripple segment of the carry-resolve adder, built from
// the fa1/ha1 cells. Every bit position adds one sum bit, one (already aligned)
// carry-vector bit and the rippling carry.
//   SW    segment width
//   LAST  1 for the most significant segment: it takes one extra addend bit
//         (cyi[W-1], weight 2^W) and folds it with the segment carry-out into
//         the two top result bits {Cout, S[W]}.
// Ports
//   i_a    sum-vector slice
//   i_b    aligned carry-vector slice (SW bits, SW+1 bits when LAST)
//   i_cin  carry into the segment's lowest bit
//   o_sum  {carry_out, sum} (SW+1 bits), or {Cout, S[W], sum} when LAST
// -----------------------------------------------------------------------------
module csa_seg_add
   import mdclcg_pkg::*;
#(
   parameter int SW   = 16,
   parameter int LAST = 0
) (
   input  logic [SW-1:0]      i_a,
   input  logic [SW-1+LAST:0] i_b,
   input  logic               i_cin,
   output logic [SW+LAST:0]   o_sum
);

   logic [SW-1:0] w_s;
   logic          w_c;

   always_comb begin
      logic [1:0] w_fa;
      // NOTE: the ripple chain reuses w_c from one bit to the next inside a
      // single pass, which only works with blocking assignments; every
      // variable also gets a value before the loop so no latch is implied.
      w_c  = i_cin;
      w_s  = '0;
      w_fa = '0;
      for (int j = 0; j < SW; j++) begin
         w_fa   = fa1(i_a[j], i_b[j], w_c);
         w_s[j] = w_fa[0];
         w_c    = w_fa[1];
      end
   end

   if (LAST != 0) begin : g_last
      logic [1:0] w_top;
      // Top addend cyi[W-1] meets the carry out of bit W-1.
      assign w_top = ha1(i_b[SW], w_c);
      assign o_sum = {w_top, w_s};
   end else begin : g_mid
      assign o_sum = {w_c, w_s};
   end

endmodule : csa_seg_add

// File: rtl/csa_resolve_pipe.sv
// -----------------------------------------------------------------------------
// csa_resolve_pipe
// Pipelined carry-resolve stage: converts a carry-save pair into binary,
//   {Cout, S} = Si1 + (cyi << 1) + Cin
// with the carry chain cut into SEGS ripple segments, one per pipeline stage.
// Stage k resolves bits [k*SW +: SW]; operand bits for later segments ride
// along in skew registers, and the low result bits accumulate stage by stage.
// The last stage register is the output register.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready = global advance enable)
//   Si1, cyi, Cin       carry-save sum vector, carry vector (bit i weighs
//                       2^(i+1)), carry-in
//   out_valid/out_ready output handshake
//   S, Cout             result bits [W:0] and bit W+1
// -----------------------------------------------------------------------------
module csa_resolve_pipe
   import mdclcg_pkg::*;
#(
   parameter int W    = MDCLCG_W,
   parameter int SEGS = MDCLCG_SEGS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] Si1,
   input  logic [W-1:0] cyi,
   input  logic         Cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W:0]   S,
   output logic         Cout
);

   localparam int SW = W / SEGS;

   if ((SEGS < 1) || (SEGS > W) || ((W % SEGS) != 0)) begin : g_bad_params
      $error("csa_resolve_pipe: W must be a multiple of SEGS and 1 <= SEGS <= W");
   end

   // Whole pipeline advances in lock-step; a full output slot that is not
   // being taken freezes every stage.
   logic w_en;
   assign w_en     = ~out_valid | out_ready;
   assign in_ready = w_en;

   // Carry vector aligned to result weight: bit 0 carries Cin, bit i>0 carries
   // cyi[i-1], bit W carries cyi[W-1].
   logic [W:0] w_c2;
   assign w_c2 = {cyi, Cin};

   for (genvar k = 0; k < SEGS; k++) begin : g_stage
      localparam int LAST = (k == SEGS - 1) ? 1 : 0;
      // Result bits held by this stage: resolved low bits plus the carry
      // (or, in the last stage, the full {Cout, S}).
      localparam int RW = (k + 1) * SW + 1 + LAST;

      logic               r_vld;
      logic [RW-1:0]      r_res;
      logic [SW-1:0]      w_a;
      logic [SW-1+LAST:0] w_b;
      logic               w_cin;
      logic [SW+LAST:0]   w_seg;
      logic [RW-1:0]      w_res;
      logic               w_vld_in;

      if (k == 0) begin : g_head
         assign w_a      = Si1[SW-1:0];
         assign w_b      = w_c2[SW-1+LAST:0];
         // Cin already sits in w_c2[0], so nothing ripples into segment 0.
         assign w_cin    = 1'b0;
         assign w_res    = w_seg;
         assign w_vld_in = in_valid;
      end else begin : g_body
         assign w_a      = g_stage[k-1].g_ops.r_a[SW-1:0];
         assign w_b      = g_stage[k-1].g_ops.r_b[SW-1+LAST:0];
         assign w_cin    = g_stage[k-1].r_res[k*SW];
         assign w_res    = {w_seg, g_stage[k-1].r_res[k*SW-1:0]};
         assign w_vld_in = g_stage[k-1].r_vld;
      end

      csa_seg_add #(
         .SW   (SW),
         .LAST (LAST)
      ) u_seg (
         .i_a   (w_a),
         .i_b   (w_b),
         .i_cin (w_cin),
         .o_sum (w_seg)
      );

      always_ff @(posedge clk) begin
         if (rst) begin
            r_vld <= 1'b0;
            r_res <= '0;
         end else if (w_en) begin
            r_vld <= w_vld_in;
            r_res <= w_res;
         end
      end

      // Skew registers: operand bits still waiting for a later segment.
      if (LAST == 0) begin : g_ops
         localparam int AW = W - (k + 1) * SW;

         logic [AW-1:0] r_a;
         logic [AW:0]   r_b;
         logic [AW-1:0] w_a_rest;
         logic [AW:0]   w_b_rest;

         if (k == 0) begin : g_src_in
            assign w_a_rest = Si1[W-1:SW];
            assign w_b_rest = w_c2[W:SW];
         end else begin : g_src_prev
            assign w_a_rest = g_stage[k-1].g_ops.r_a[W-k*SW-1:SW];
            assign w_b_rest = g_stage[k-1].g_ops.r_b[W-k*SW:SW];
         end

         // NOTE: pure datapath with no reset; the valid chain alone decides
         // whether these bits mean anything, so clearing them buys nothing.
         always_ff @(posedge clk) begin
            if (w_en) begin
               r_a <= w_a_rest;
               r_b <= w_b_rest;
            end
         end
      end
   end

   assign out_valid = g_stage[SEGS-1].r_vld;
   assign S         = g_stage[SEGS-1].r_res[W:0];
   assign Cout      = g_stage[SEGS-1].r_res[W+1];

endmodule : csa_resolve_pipe

// File: tb/tb_csa_resolve_pipe.sv
// -----------------------------------------------------------------------------
// tb_csa_resolve_pipe
// Three instances: (W,SEGS) = (64,4), (64,1), (32,8). Directed cases run on
// instance 0; a random handshake phase then drives all three at once. A
// scoreboard queues the arithmetic result of every accepted input and checks
// every consumed output against it in order.
// -----------------------------------------------------------------------------
module tb_csa_resolve_pipe;

   localparam int N = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0] in_valid  = '0;
   logic [N-1:0] out_ready = '1;
   logic [N-1:0] cin       = '0;
   wire  [N-1:0] in_ready;
   wire  [N-1:0] out_valid;
   logic [63:0]  si [N];
   logic [63:0]  cy [N];

   logic [64:0]  s0, s1;
   logic [32:0]  s2;
   logic         c0, c1, c2;
   logic [65:0]  res [N];

   always_comb begin
      res[0] = {c0, s0};
      res[1] = {c1, s1};
      res[2] = {32'd0, c2, s2};
   end

   csa_resolve_pipe #(.W(64), .SEGS(4)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .Si1(si[0]), .cyi(cy[0]), .Cin(cin[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .S(s0), .Cout(c0));

   csa_resolve_pipe #(.W(64), .SEGS(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .Si1(si[1]), .cyi(cy[1]), .Cin(cin[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .S(s1), .Cout(c1));

   csa_resolve_pipe #(.W(32), .SEGS(8)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .Si1(si[2][31:0]), .cyi(cy[2][31:0]), .Cin(cin[2]), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .S(s2), .Cout(c2));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands, width-limited.
   function automatic logic [65:0] model(input int w, input logic [63:0] a,
                                         input logic [63:0] b, input logic c);
      logic [65:0] av, bv;
      av = {2'b00, a};
      bv = {2'b00, b};
      if (w == 32) begin
         av[65:32] = '0;
         bv[65:32] = '0;
      end
      return av + (bv << 1) + {65'd0, c};
   endfunction

   function automatic int width_of(input int i);
      return (i == 2) ? 32 : 64;
   endfunction

   // Scoreboard, sampled mid-cycle so handshakes reflect the coming edge.
   logic [65:0] exp_q [N][$];
   int          n_acc [N] = '{default: 0};

   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) exp_q[i].delete();
      end else begin
         for (int i = 0; i < N; i++) begin
            if (out_valid[i] && out_ready[i]) begin
               check($sformatf("sb%0d_pending", i), 66'(exp_q[i].size() != 0), 66'd1);
               if (exp_q[i].size() != 0)
                  check($sformatf("sb%0d_data", i), res[i], exp_q[i].pop_front());
            end
            if (in_valid[i] && in_ready[i]) begin
               exp_q[i].push_back(model(width_of(i), si[i], cy[i], cin[i]));
               n_acc[i]++;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before the bench finished");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send0(input logic [63:0] a, input logic [63:0] b, input logic c);
      si[0] = a; cy[0] = b; cin[0] = c; in_valid[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
   endtask

   task automatic wait_out0(input string tag, output logic [65:0] r);
      int n;
      n = 0;
      while (!out_valid[0] && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_seen"}, 66'(out_valid[0]), 66'd1);
      r = res[0];
   endtask

   initial begin
      logic [65:0] r;
      int lat, first, last, cnt, sent, stall_cnt, seen, cyc;
      logic [65:0] held;

      for (int i = 0; i < N; i++) begin si[i] = '0; cy[i] = '0; end

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      check("rst_out_valid0", 66'(out_valid[0]), 66'd0);
      check("rst_res0", res[0], 66'd0);
      check("rst_in_ready0", 66'(in_ready[0]), 66'd1);
      check("rst_out_valid1", 66'(out_valid[1]), 66'd0);
      check("rst_out_valid2", 66'(out_valid[2]), 66'd0);
      rst = 1'b0;

      // Single transaction: latency and value
      send0(64'd0, 64'd0, 1'b1);
      check("t1_no_early", 66'(out_valid[0]), 66'd0);
      lat = 0;
      while (!out_valid[0] && lat < 20) begin
         tick();
         lat++;
      end
      check("t1_latency", 66'(lat), 66'd3);
      check("t1_result", res[0], 66'd1);
      tick();

      // Carry crossing every segment
      send0(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
      wait_out0("t2", r);
      check("t2_result", r, 66'h1_0000_0000_0000_0000);
      tick();

      // All ones everywhere
      send0(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      wait_out0("t3", r);
      check("t3_result", r, 66'h2_FFFF_FFFF_FFFF_FFFE);
      tick();

      // Eight back-to-back inputs
      first = -1; last = -1; cnt = 0;
      for (int c = 0; c < 16; c++) begin
         if (c < 8) begin
            in_valid[0] = 1'b1;
            si[0] = {$urandom, $urandom};
            cy[0] = {$urandom, $urandom};
            cin[0] = 1'($urandom);
         end else begin
            in_valid[0] = 1'b0;
         end
         tick();
         if (out_valid[0]) begin
            if (first < 0) first = c;
            last = c;
            cnt++;
         end
      end
      check("t4_first", 66'(first), 66'd3);
      check("t4_count", 66'(cnt), 66'd8);
      check("t4_last", 66'(last), 66'd10);

      // Three-cycle output stall mid-stream
      sent = 0; stall_cnt = 0; held = '0;
      out_ready[0] = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (out_valid[0] && stall_cnt == 0) begin
            held = res[0];
            out_ready[0] = 1'b0;
            stall_cnt = 1;
         end else if (stall_cnt >= 1 && stall_cnt <= 3) begin
            check("t5_hold_data", res[0], held);
            check("t5_hold_valid", 66'(out_valid[0]), 66'd1);
            out_ready[0] = (stall_cnt == 3);
            stall_cnt++;
         end
         if (sent < 8) begin
            in_valid[0] = 1'b1;
            si[0] = {$urandom, $urandom};
            cy[0] = {$urandom, $urandom};
            cin[0] = 1'($urandom);
         end else begin
            in_valid[0] = 1'b0;
         end
         #1;
         if (!out_ready[0]) check("t5_in_ready_low", 66'(in_ready[0]), 66'd0);
         if (in_valid[0] && in_ready[0]) sent++;
         tick();
      end
      check("t5_sent", 66'(sent), 66'd8);
      in_valid[0] = 1'b0;
      out_ready[0] = 1'b1;
      repeat (8) tick();
      check("t5_drained", 66'(exp_q[0].size()), 66'd0);

      // Reset with three transactions in flight
      for (int c = 0; c < 3; c++) begin
         in_valid[0] = 1'b1;
         si[0] = {$urandom, $urandom};
         cy[0] = {$urandom, $urandom};
         cin[0] = 1'($urandom);
         tick();
      end
      in_valid[0] = 1'b0;
      rst = 1'b1;
      tick();
      check("t6_flushed", 66'(out_valid[0]), 66'd0);
      check("t6_in_ready", 66'(in_ready[0]), 66'd1);
      rst = 1'b0;
      seen = 0;
      repeat (6) begin
         tick();
         if (out_valid[0]) seen++;
      end
      check("t6_no_ghost", 66'(seen), 66'd0);
      send0(64'd123, 64'd45, 1'b0);
      wait_out0("t6", r);
      check("t6_first_after", r, 66'd213);
      tick();

      // Random handshakes on all three configurations
      cyc = 0;
      while ((n_acc[0] < 10000 || n_acc[1] < 10000 || n_acc[2] < 10000) && cyc < 60000) begin
         for (int i = 0; i < N; i++) begin
            int pat;
            in_valid[i]  = ($urandom_range(3) != 0);
            out_ready[i] = ($urandom_range(3) != 0);
            pat = int'($urandom_range(7));
            si[i]  = (pat == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            cy[i]  = (pat == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            cin[i] = 1'($urandom);
         end
         tick();
         cyc++;
      end
      in_valid  = '0;
      out_ready = '1;
      repeat (20) tick();
      for (int i = 0; i < N; i++) begin
         check($sformatf("t7_acc%0d", i), 66'(n_acc[i] >= 10000), 66'd1);
         check($sformatf("t7_drained%0d", i), 66'(exp_q[i].size()), 66'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_csa_resolve_pipe
